// File: rtl/apb_requester_if.sv
// Command/response port plus APB bus for the single-outstanding APB requester.
interface apb_requester_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    // Command side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // Response side
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB side
    logic                  psel;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    // Requester view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, paddr, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    // Environment view (command source, response sink and APB peripheral)
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, paddr, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS sequencing,
// wait-state timeout, one-cycle response pulse out. All bus and response outputs registered.
module apb_requester #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ALIGNBITS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic             pclk,
    input logic             preset,
    apb_requester_if.master bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StReject} state_e;

    // Wait counter value at which a stalled ACCESS is abandoned
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic cmd_ready;
    logic accept;
    logic misaligned;

    // Ready in IDLE, or in the ACCESS completion cycle so a new command can chain
    always_comb begin
        cmd_ready  = (state_q == StIdle) || ((state_q == StAccess) && bus.pready);
        accept     = bus.cmd_valid && cmd_ready;
        misaligned = |bus.cmd_addr[ALIGNBITS-1:0];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
            StSetup: begin
                state_d    = StAccess;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            StAccess: begin
                if (bus.pready) begin
                    state_d     = StIdle;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    if (!pwrite_q && !bus.pslverr) begin
                        rsp_rdata_d = bus.prdata;
                    end
                end else if (wait_cnt_q == WaitLast) begin
                    state_d       = StIdle;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StReject: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: begin
                state_d   = StIdle;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // Acceptance overrides the idle/completion transition; psel stays high when chaining
        if (accept) begin
            paddr_d   = bus.cmd_addr;
            pwrite_d  = bus.cmd_write;
            pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
            penable_d = 1'b0;
            if (misaligned) begin
                state_d = StReject;
                psel_d  = 1'b0;
            end else begin
                state_d = StSetup;
                psel_d  = 1'b1;
            end
        end
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed scenarios plus randomized commands
// checked against a latency/result model derived from the transfer rules.
module tb_apb_requester;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    int   n_vec  = 0;
    int   n_err  = 0;

    always #5 pclk = ~pclk;

    apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_requester #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .ALIGNBITS     (2),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus)
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;
    endtask

    // One command from IDLE to its response; expectations come from the transfer rules
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic serr, input logic [31:0] rdata,
                           input string name);
        logic        mis;
        int          exp_lat, exp_acc, k, acc;
        logic        exp_err, exp_to, got, in_access;
        logic [31:0] exp_rd, exp_wd;

        mis    = (addr[1:0] != 2'b00);
        exp_wd = wr ? wdata : 32'h0;
        if (mis) begin
            exp_lat = 2; exp_acc = 0; exp_err = 1'b1; exp_to = 1'b0; exp_rd = 32'h0;
        end else if (waits >= int'(TMO)) begin
            exp_lat = TMO + 2; exp_acc = TMO; exp_err = 1'b1; exp_to = 1'b1; exp_rd = 32'h0;
        end else begin
            exp_lat = 3 + waits; exp_acc = waits + 1; exp_err = serr; exp_to = 1'b0;
            exp_rd  = (!wr && !serr) ? rdata : 32'h0;
        end

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.pready    = 1'b0;
        @(negedge pclk);
        n_vec++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL %s cmd_ready in idle: got %b want 1", name, bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;

        k = 1; acc = 0; got = 1'b0;
        while (!got && k <= int'(TMO) + 6) begin
            in_access   = bus.psel && bus.penable;
            bus.pready  = in_access && (acc == waits);
            bus.pslverr = bus.pready ? serr : 1'($urandom_range(0, 1));
            bus.prdata  = bus.pready ? rdata : $urandom;
            @(negedge pclk);
            if (k == 1) begin
                n_vec++;
                if ({bus.psel, bus.penable} !== {!mis, 1'b0}) begin
                    n_err++;
                    $display("FAIL %s first-cycle psel/penable: got %b%b want %b0", name,
                             bus.psel, bus.penable, !mis);
                end
            end
            if (in_access) begin
                acc++;
                n_vec++;
                if ({bus.paddr, bus.pwrite, bus.pwdata} !== {addr, wr, exp_wd}) begin
                    n_err++;
                    $display("FAIL %s access bus: got %h/%b/%h want %h/%b/%h", name,
                             bus.paddr, bus.pwrite, bus.pwdata, addr, wr, exp_wd);
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1;
                n_vec++;
                if (k != exp_lat) begin
                    n_err++; $display("FAIL %s latency: got %0d want %0d", name, k, exp_lat);
                end
                n_vec++;
                if ({bus.rsp_err, bus.rsp_timeout} !== {exp_err, exp_to}) begin
                    n_err++;
                    $display("FAIL %s err/timeout: got %b%b want %b%b", name,
                             bus.rsp_err, bus.rsp_timeout, exp_err, exp_to);
                end
                n_vec++;
                if (bus.rsp_rdata !== exp_rd) begin
                    n_err++;
                    $display("FAIL %s rdata: got %h want %h", name, bus.rsp_rdata, exp_rd);
                end
            end
            tick();
            k++;
        end
        bus.pready = 1'b0;
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL %s response: got none want one within %0d", name, TMO + 6);
        end
        n_vec++;
        if (acc != exp_acc) begin
            n_err++; $display("FAIL %s access cycles: got %0d want %0d", name, acc, exp_acc);
        end
        @(negedge pclk);
        n_vec++;
        if ({bus.rsp_valid, bus.psel, bus.penable} !== 3'b000) begin
            n_err++;
            $display("FAIL %s after response: got rsp_valid/psel/penable %b%b%b want 000",
                     name, bus.rsp_valid, bus.psel, bus.penable);
        end
        tick();
    endtask

    task automatic test_reset();
        quiet_inputs();
        preset        = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h10;
        bus.pready    = 1'b1;
        repeat (3) tick();
        preset = 1'b0;
        quiet_inputs();
        @(negedge pclk);
        n_vec++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}
            !== 6'b0) begin
            n_err++;
            $display("FAIL reset ctrl: got %b%b%b%b%b%b want 000000", bus.psel, bus.penable,
                     bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout);
        end
        n_vec++;
        if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
            n_err++;
            $display("FAIL reset data: got %h/%h/%h want 0", bus.paddr, bus.pwdata,
                     bus.rsp_rdata);
        end
        n_vec++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset cmd_ready: got %b want 1", bus.cmd_ready);
        end
        tick();
    endtask

    task automatic test_directed();
        run_cmd(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0, "write_zero_wait");
        run_cmd(1'b0, 32'h04, 32'h0, 3, 1'b0, 32'h12345678, "read_3_waits");
        run_cmd(1'b1, 32'h06, 32'h55AA55AA, 0, 1'b0, 32'h0, "misaligned");
        run_cmd(1'b0, 32'h30, 32'h0, TMO - 1, 1'b0, 32'hCAFE0001, "last_wait_ok");
        run_cmd(1'b0, 32'h34, 32'h0, TMO + 4, 1'b0, 32'h0, "timeout");
    endtask

    task automatic test_back_to_back();
        // Read with slave error, write chained behind it
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h08;
        tick();
        bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0C; bus.cmd_wdata = 32'hCAFEF00D;
        @(negedge pclk);
        n_vec++;
        if ({bus.psel, bus.penable, bus.cmd_ready, bus.paddr} !== {3'b100, 32'h08}) begin
            n_err++; $display("FAIL b2b setup: got %b%b%b %h want 100 00000008",
                              bus.psel, bus.penable, bus.cmd_ready, bus.paddr);
        end
        tick();
        bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'hA5A5A5A5;
        @(negedge pclk);
        n_vec++;
        if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b111) begin
            n_err++; $display("FAIL b2b completion: got %b%b%b want 111",
                              bus.psel, bus.penable, bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        @(negedge pclk);
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== {3'b110, 32'h0})
        begin
            n_err++; $display("FAIL b2b first rsp: got %b%b%b %h want 110 00000000",
                              bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
        end
        n_vec++;
        if ({bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata}
            !== {2'b10, 32'h0C, 1'b1, 32'hCAFEF00D}) begin
            n_err++; $display("FAIL b2b second setup: got %b%b %h %b %h want 10 0000000c 1 cafef00d",
                              bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata);
        end
        tick();
        bus.pready = 1'b1;
        @(negedge pclk);
        n_vec++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
            n_err++; $display("FAIL b2b second access: got %b%b%b want 110",
                              bus.psel, bus.penable, bus.rsp_valid);
        end
        tick();
        bus.pready = 1'b0;
        @(negedge pclk);
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.psel} !== {2'b10, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL b2b second rsp: got %b%b %h psel %b want 10 00000000 psel 0",
                              bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.psel);
        end
        tick();

        // Read completion with a misaligned command chained behind it
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h20;
        tick();
        bus.cmd_write = 1'b1; bus.cmd_addr = 32'h22;
        tick();
        bus.pready = 1'b1; bus.prdata = 32'h11223344;
        tick();
        bus.cmd_valid = 1'b0; bus.pready = 1'b0;
        @(negedge pclk);
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.psel} !== {2'b10, 32'h11223344, 1'b0})
        begin
            n_err++; $display("FAIL chain-reject read rsp: got %b%b %h psel %b want 10 11223344 psel 0",
                              bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.psel);
        end
        tick();
        @(negedge pclk);
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== {3'b110, 32'h0})
        begin
            n_err++; $display("FAIL chain-reject reject rsp: got %b%b%b %h want 110 00000000",
                              bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
        end
        tick();
        @(negedge pclk);
        n_vec++;
        if (bus.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL chain-reject extra pulse: got %b want 0", bus.rsp_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h40;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        preset = 1'b1;
        tick();
        preset = 1'b0;
        @(negedge pclk);
        n_vec++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b000) begin
            n_err++; $display("FAIL reset_mid bus: got %b%b%b want 000",
                              bus.psel, bus.penable, bus.rsp_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.pready  = 1'($urandom_range(0, 1));
            bus.pslverr = 1'($urandom_range(0, 1));
            @(negedge pclk);
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL reset_mid quiet: got activity after reset want none");
        end
        tick();
        bus.pready = 1'b0; bus.pslverr = 1'b0;
        run_cmd(1'b1, 32'h44, 32'h0BADF00D, 1, 1'b0, 32'h0, "after_reset_mid");
    endtask

    task automatic test_random();
        logic        wr, serr;
        logic [31:0] addr, wdata, rdata;
        int          waits, r;
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom_range(0, 1));
            serr  = ($urandom_range(0, 3) == 0);
            wdata = $urandom;
            rdata = $urandom;
            addr  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            r = int'($urandom_range(0, 9));
            if (r <= 6)      waits = int'($urandom_range(0, 3));
            else if (r == 7) waits = TMO - 1;
            else if (r == 8) waits = TMO;
            else             waits = int'($urandom_range(5, 10));
            run_cmd(wr, addr, wdata, waits, serr, rdata, $sformatf("random%0d", i));
        end
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
